// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: state encodings, requester IDs and the
// grant rule shared by the SDRAM request arbiter.
package sdram_arbiter_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ISSUE    = 2'd1;
   localparam logic [1:0] ST_WAIT_RSP = 2'd2;
   localparam logic [1:0] ST_RESP     = 2'd3;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   // DMA wins when it is alone, when the CPU had the last grant,
   // or while it still holds burst credit.
   function automatic logic dma_wins(
      input logic cpu_v,
      input logic dma_v,
      input logic last_dma,
      input logic credit
   );
      return dma_v & (~cpu_v | ~last_dma | credit);
   endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: CPU, DMA and SDRAM-controller request/response
// signals; slave = arbiter view, master = requester/controller view.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
);
   logic              cpu_req_valid;
   logic [ADDR_W-1:0] cpu_req_addr;
   logic              cpu_req_rw;
   logic [3:0]        cpu_req_sel;
   logic [DATA_W-1:0] cpu_req_wdata;
   logic              cpu_req_ack;
   logic [DATA_W-1:0] cpu_rsp_rdata;

   logic              dma_req_valid;
   logic [ADDR_W-1:0] dma_req_addr;
   logic              dma_req_rw;
   logic [DATA_W-1:0] dma_req_wdata;
   logic              dma_req_ack;
   logic [DATA_W-1:0] dma_rsp_rdata;

   logic              sdr_req_valid;
   logic [ADDR_W-1:0] sdr_req_addr;
   logic              sdr_req_rw;
   logic [3:0]        sdr_req_sel;
   logic [DATA_W-1:0] sdr_req_wdata;
   logic              sdr_req_ready;
   logic              sdr_rsp_valid;
   logic [DATA_W-1:0] sdr_rsp_rdata;

   logic              arb_busy;
   logic              arb_grant_dma;

   modport slave (
      input  cpu_req_valid, cpu_req_addr, cpu_req_rw,
      input  cpu_req_sel, cpu_req_wdata,
      output cpu_req_ack, cpu_rsp_rdata,
      input  dma_req_valid, dma_req_addr, dma_req_rw,
      input  dma_req_wdata,
      output dma_req_ack, dma_rsp_rdata,
      output sdr_req_valid, sdr_req_addr, sdr_req_rw,
      output sdr_req_sel, sdr_req_wdata,
      input  sdr_req_ready, sdr_rsp_valid, sdr_rsp_rdata,
      output arb_busy, arb_grant_dma
   );

   modport master (
      output cpu_req_valid, cpu_req_addr, cpu_req_rw,
      output cpu_req_sel, cpu_req_wdata,
      input  cpu_req_ack, cpu_rsp_rdata,
      output dma_req_valid, dma_req_addr, dma_req_rw,
      output dma_req_wdata,
      input  dma_req_ack, dma_rsp_rdata,
      input  sdr_req_valid, sdr_req_addr, sdr_req_rw,
      input  sdr_req_sel, sdr_req_wdata,
      output sdr_req_ready, sdr_rsp_valid, sdr_rsp_rdata,
      input  arb_busy, arb_grant_dma
   );

endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between CPU and
// DMA; one transaction in flight, round-robin with DMA burst credit.
module sdram_arbiter #(
   parameter int ADDR_W    = 23,
   parameter int DATA_W    = 32,
   parameter int DMA_BURST = 4
) (
   input logic            wb_clk_i,
   input logic            wb_rst_i,
   sdram_arbiter_if.slave bus
);
   import sdram_arbiter_pkg::*;

   localparam int SW = $clog2(DMA_BURST + 1);
   localparam logic [SW-1:0] BURST_LIM = SW'(DMA_BURST);

   logic [1:0]        state;
   logic [SW-1:0]     dma_streak;
   logic              credit;
   logic              pick_any;
   logic              pick_dma;
   logic [ADDR_W-1:0] pick_addr;
   logic              pick_rw;
   logic [3:0]        pick_sel;
   logic [DATA_W-1:0] pick_wdata;

   // busy whenever a transaction is anywhere in flight
   assign bus.arb_busy = (state != ST_IDLE);

   // winner choice and request field mux for the IDLE decision
   always_comb begin
      credit     = (dma_streak < BURST_LIM);
      pick_any   = bus.cpu_req_valid | bus.dma_req_valid;
      pick_dma   = dma_wins(bus.cpu_req_valid, bus.dma_req_valid,
                            bus.arb_grant_dma, credit);
      pick_addr  = bus.cpu_req_addr;
      pick_rw    = bus.cpu_req_rw;
      pick_sel   = bus.cpu_req_sel;
      pick_wdata = bus.cpu_req_wdata;
      if (pick_dma == REQ_DMA) begin
         pick_addr  = bus.dma_req_addr;
         pick_rw    = bus.dma_req_rw;
         pick_sel   = 4'hF;
         pick_wdata = bus.dma_req_wdata;
      end
   end

   // transaction sequencer: grant, issue, await response, acknowledge
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state             <= ST_IDLE;
         dma_streak        <= '0;
         bus.sdr_req_valid <= 1'b0;
         bus.sdr_req_addr  <= '0;
         bus.sdr_req_rw    <= 1'b0;
         bus.sdr_req_sel   <= 4'h0;
         bus.sdr_req_wdata <= '0;
         bus.cpu_req_ack   <= 1'b0;
         bus.dma_req_ack   <= 1'b0;
         bus.cpu_rsp_rdata <= '0;
         bus.dma_rsp_rdata <= '0;
         bus.arb_grant_dma <= REQ_CPU;
      end else begin
         bus.cpu_req_ack <= 1'b0;
         bus.dma_req_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  state             <= ST_ISSUE;
                  bus.sdr_req_valid <= 1'b1;
                  bus.sdr_req_addr  <= pick_addr;
                  bus.sdr_req_rw    <= pick_rw;
                  bus.sdr_req_sel   <= pick_sel;
                  bus.sdr_req_wdata <= pick_wdata;
                  bus.arb_grant_dma <= pick_dma;
                  if (pick_dma == REQ_DMA) begin
                     if (dma_streak != BURST_LIM)
                        dma_streak <= dma_streak + SW'(1);
                  end else begin
                     dma_streak <= '0;
                  end
               end
            end
            ST_ISSUE: begin
               if (bus.sdr_req_ready) begin
                  bus.sdr_req_valid <= 1'b0;
                  state             <= ST_WAIT_RSP;
               end
            end
            ST_WAIT_RSP: begin
               if (bus.sdr_rsp_valid) begin
                  if (bus.arb_grant_dma == REQ_DMA) begin
                     bus.dma_rsp_rdata <= bus.sdr_rsp_rdata;
                     bus.dma_req_ack   <= 1'b1;
                  end else begin
                     bus.cpu_rsp_rdata <= bus.sdr_rsp_rdata;
                     bus.cpu_req_ack   <= 1'b1;
                  end
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               // ack cycle; requester valids are deliberately ignored here
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of the SDRAM
// arbiter against a transaction-level grant/response model.
module tb_sdram_arbiter;
   localparam int AW      = 23;
   localparam int DW      = 32;
   localparam int BURST_A = 4;

   logic clk   = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
   sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

   sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DMA_BURST(BURST_A)) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst_a), .bus(ia.slave)
   );
   sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DMA_BURST(1)) dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst_b), .bus(ib.slave)
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int cyc     = 0;

   logic          c_v = 0, d_v = 0, c_drop = 0, d_drop = 0;
   logic [AW-1:0] c_addr = 0, d_addr = 0;
   logic          c_rw = 0, d_rw = 0;
   logic [3:0]    c_sel = 0;
   logic [DW-1:0] c_wd = 0, d_wd = 0;

   bit            rand_req = 0, auto_both = 0, use_fixed = 0, spurious = 0;
   int            p_req = 25, ready_prob = 100, ready_low = 0;
   int            rsp_dly_max = 0, rsp_dly_fix = 0;
   logic [DW-1:0] fixed_data = 0;

   logic          ready = 0, rsp_real = 0, rsp_drive = 0;
   logic [DW-1:0] rsp_data = 0;
   bit            acc_pending = 0, waiting = 0;
   int            rsp_cnt = 0;

   bit            m_last = 0, m_active = 0, m_owner = 0, post_ack = 0;
   int            m_streak = 0;
   logic [59:0]   e_fields = 0;
   int            acks_cpu = 0, acks_dma = 0;
   bit            ack_log[$];
   bit            b_log[$];
   bit            b_on = 0, b_acc = 0;
   logic [DW-1:0] b_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // grant rule as stated: lone requester wins; with both pending the
   // DMA wins after a CPU grant or while fewer than BURST_A in a row
   function automatic bit model_pick(input bit cv, input bit dv);
      bit dma;
      if (cv && dv) dma = !m_last || (m_streak < BURST_A);
      else dma = dv;
      if (dma) m_streak = (m_streak < BURST_A) ? m_streak + 1 : m_streak;
      else m_streak = 0;
      m_last = dma;
      return dma;
   endfunction

   task automatic drive();
      ia.cpu_req_valid = c_v;
      ia.cpu_req_addr  = c_addr;
      ia.cpu_req_rw    = c_rw;
      ia.cpu_req_sel   = c_sel;
      ia.cpu_req_wdata = c_wd;
      ia.dma_req_valid = d_v;
      ia.dma_req_addr  = d_addr;
      ia.dma_req_rw    = d_rw;
      ia.dma_req_wdata = d_wd;
      ia.sdr_req_ready = ready;
      ia.sdr_rsp_valid = rsp_drive;
      ia.sdr_rsp_rdata = rsp_drive ? rsp_data : DW'($urandom);
   endtask

   task automatic raise_cpu(input logic [AW-1:0] a, input logic rw,
                            input logic [3:0] sel, input logic [DW-1:0] wd);
      c_v = 1; c_addr = a; c_rw = rw; c_sel = sel; c_wd = wd;
      drive();
   endtask

   task automatic raise_dma(input logic [AW-1:0] a, input logic rw,
                            input logic [DW-1:0] wd);
      d_v = 1; d_addr = a; d_rw = rw; d_wd = wd;
      drive();
   endtask

   task automatic tick();
      bit fired;
      logic [59:0] obs;
      @(posedge clk);
      #1;
      cyc++;
      fired = rsp_real;
      if (rst_a) begin
         c_v = 0; d_v = 0; c_drop = 0; d_drop = 0;
         m_active = 0; m_last = 0; m_streak = 0; post_ack = 0;
         acc_pending = 0; waiting = 0; rsp_real = 0; rsp_drive = 0;
         ready = 0;
      end else begin
         if (post_ack) begin
            chk("idle_after_ack", 64'(ia.arb_busy), 64'(0));
            post_ack = 0;
         end
         chk("cpu_ack", 64'(ia.cpu_req_ack), 64'(fired && m_active && !m_owner));
         chk("dma_ack", 64'(ia.dma_req_ack), 64'(fired && m_active && m_owner));
         if (fired && m_active) begin
            if (m_owner) begin
               chk("dma_rdata", 64'(ia.dma_rsp_rdata), 64'(rsp_data));
               acks_dma++; d_drop = 1;
            end else begin
               chk("cpu_rdata", 64'(ia.cpu_rsp_rdata), 64'(rsp_data));
               acks_cpu++; c_drop = 1;
            end
            ack_log.push_back(m_owner);
            m_active = 0;
            post_ack = 1;
         end
         obs = {ia.sdr_req_addr, ia.sdr_req_rw, ia.sdr_req_sel, ia.sdr_req_wdata};
         if (ia.sdr_req_valid === 1'b1) begin
            if (!m_active) begin
               chk("req_present", 64'(c_v | d_v), 64'(1));
               m_owner  = model_pick(c_v, d_v);
               m_active = 1;
               e_fields = m_owner ? {d_addr, d_rw, 4'hF, d_wd}
                                  : {c_addr, c_rw, c_sel, c_wd};
               chk("winner", 64'(ia.arb_grant_dma), 64'(m_owner));
            end
            chk("req_fields", 64'(obs), 64'(e_fields));
         end
         if (acc_pending) begin
            chk("valid_after_accept", 64'(ia.sdr_req_valid), 64'(0));
            acc_pending = 0;
            waiting = 1;
            rsp_cnt = (rsp_dly_fix >= 0) ? rsp_dly_fix
                                         : int'($urandom_range(rsp_dly_max));
         end
         rsp_real = 0;
         rsp_drive = 0;
         if (waiting) begin
            if (rsp_cnt == 0) begin
               waiting = 0; rsp_real = 1; rsp_drive = 1;
               rsp_data = use_fixed ? fixed_data : DW'($urandom);
            end else begin
               rsp_cnt--;
            end
         end
         if (spurious) begin
            rsp_drive = 1; rsp_data = DW'($urandom); spurious = 0;
         end
         if (ready_low > 0) begin
            ready = 0; ready_low--;
         end else begin
            ready = (int'($urandom_range(99)) < ready_prob);
         end
         if (ia.sdr_req_valid === 1'b1 && ready) acc_pending = 1;
         if (c_drop) begin c_v = 0; c_drop = 0; end
         if (d_drop) begin d_v = 0; d_drop = 0; end
         if (!c_v && (auto_both || (rand_req && int'($urandom_range(99)) < p_req))) begin
            c_v = 1; c_addr = {1'b0, 22'($urandom)}; c_rw = 1'($urandom);
            c_sel = 4'($urandom); c_wd = DW'($urandom);
         end
         if (!d_v && (auto_both || (rand_req && int'($urandom_range(99)) < p_req))) begin
            d_v = 1; d_addr = {1'b1, 22'($urandom)}; d_rw = 1'($urandom);
            d_wd = DW'($urandom);
         end
      end
      if (rst_b) b_acc = 0;
      else if (ib.cpu_req_ack === 1'b1) b_log.push_back(1'b0);
      else if (ib.dma_req_ack === 1'b1) b_log.push_back(1'b1);
      ib.sdr_rsp_valid = b_acc && !rst_b;
      ib.sdr_rsp_rdata = b_cnt;
      b_cnt++;
      b_acc = (ib.sdr_req_valid === 1'b1);
      ib.cpu_req_valid = b_on;
      ib.dma_req_valid = b_on;
      drive();
   endtask

   task automatic wait_ack(input bit dma, input int budget, input string tag);
      int base;
      int k;
      base = dma ? acks_dma : acks_cpu;
      k = 0;
      while (((dma ? acks_dma : acks_cpu) == base) && k < budget) begin
         tick(); k++;
      end
      chk(tag, 64'((dma ? acks_dma : acks_cpu) != base), 64'(1));
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while ((c_v || d_v || m_active) && k < 200) begin
         tick(); k++;
      end
      chk(tag, 64'(c_v || d_v || m_active), 64'(0));
      tick(); tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 64'({ia.sdr_req_valid, ia.sdr_req_rw, ia.sdr_req_sel,
          ia.cpu_req_ack, ia.dma_req_ack, ia.arb_busy, ia.arb_grant_dma}), 64'(0));
      chk({tag, "_addr"}, 64'(ia.sdr_req_addr), 64'(0));
      chk({tag, "_wdata"}, 64'(ia.sdr_req_wdata), 64'(0));
      chk({tag, "_rdata"}, 64'({ia.cpu_rsp_rdata, ia.dma_rsp_rdata}), 64'(0));
   endtask

   task automatic reset_a();
      rst_a = 1;
      tick();
      chk_zero("reset");
      rst_a = 0;
      tick();
   endtask

   initial begin
      int t0;
      int n0;
      int base;
      int k;
      ib.cpu_req_addr = '0; ib.cpu_req_rw = 0; ib.cpu_req_sel = 4'h0;
      ib.cpu_req_wdata = '0; ib.dma_req_addr = '0; ib.dma_req_rw = 0;
      ib.dma_req_wdata = '0; ib.sdr_req_ready = 1; ib.sdr_rsp_valid = 0;
      ib.sdr_rsp_rdata = '0; ib.cpu_req_valid = 0; ib.dma_req_valid = 0;
      drive();
      tick();
      reset_a();
      chk("idle_busy", 64'(ia.arb_busy), 64'(0));

      use_fixed = 1; fixed_data = 32'hDEADBEEF;
      rsp_dly_fix = 0; ready_prob = 100;
      n0 = acks_cpu;
      raise_dma(23'h000100, 1'b0, 32'h0);
      t0 = cyc;
      wait_ack(1, 20, "t1_ack");
      chk("t1_latency", 64'(cyc - t0), 64'(3));
      chk("t1_rdata", 64'(ia.dma_rsp_rdata), 64'(32'hDEADBEEF));
      tick(); tick();
      chk("t1_rdata_held", 64'(ia.dma_rsp_rdata), 64'(32'hDEADBEEF));
      chk("t1_no_cpu_ack", 64'(acks_cpu - n0), 64'(0));

      use_fixed = 0;
      raise_cpu(23'h001234, 1'b1, 4'b0011, 32'h12345678);
      k = 0;
      while (ia.sdr_req_valid !== 1'b1 && k < 10) begin tick(); k++; end
      chk("t2_sel", 64'(ia.sdr_req_sel), 64'(4'b0011));
      chk("t2_rw", 64'(ia.sdr_req_rw), 64'(1));
      chk("t2_grant", 64'(ia.arb_grant_dma), 64'(0));
      n0 = acks_cpu;
      wait_ack(0, 20, "t2_ack");
      tick(); tick(); tick();
      chk("t2_one_ack", 64'(acks_cpu - n0), 64'(1));

      n0 = acks_cpu + acks_dma;
      spurious = 1;
      tick(); tick(); tick();
      chk("spur_busy", 64'(ia.arb_busy), 64'(0));
      chk("spur_no_ack", 64'(acks_cpu + acks_dma - n0), 64'(0));

      ready_low = 10;
      raise_cpu({1'b0, 22'($urandom)}, 1'b0, 4'hF, 32'h0);
      t0 = cyc;
      wait_ack(0, 40, "t5_ack");
      chk("t5_latency", 64'(cyc - t0), 64'(13));
      tick(); tick();

      reset_a();
      rsp_dly_fix = -1; rsp_dly_max = 3; ready_prob = 70;
      base = ack_log.size();
      auto_both = 1;
      k = 0;
      while (ack_log.size() < base + 10 && k < 300) begin tick(); k++; end
      chk("t3_count", 64'(ack_log.size() >= base + 10), 64'(1));
      for (int i = 0; i < 10; i++)
         chk("t3_order", 64'(ack_log[base+i]), 64'((i % 5) < 4));
      auto_both = 0;
      drain("t3_drain");

      rst_b = 0; b_on = 1;
      k = 0;
      while (b_log.size() < 6 && k < 100) begin tick(); k++; end
      chk("t4_count", 64'(b_log.size() >= 6), 64'(1));
      for (int i = 0; i < 6; i++)
         chk("t4_order", 64'(b_log[i]), 64'((i % 2) == 0));
      b_on = 0;

      rand_req = 1; p_req = 25; ready_prob = 60; rsp_dly_max = 3;
      n0 = acks_cpu + acks_dma;
      repeat (800) tick();
      rand_req = 0;
      drain("rand_drain");
      chk("rand_progress", 64'(acks_cpu + acks_dma - n0 > 50), 64'(1));

      rsp_dly_fix = 20; ready_prob = 100;
      raise_dma({1'b1, 22'($urandom)}, 1'b0, 32'h0);
      k = 0;
      while (!waiting && k < 10) begin tick(); k++; end
      chk("t6_in_wait", 64'({waiting, ia.arb_busy}), 64'(2'b11));
      n0 = acks_cpu + acks_dma;
      rst_a = 1;
      tick();
      chk_zero("t6_reset");
      rst_a = 0;
      spurious = 1;
      tick(); tick(); tick();
      chk("t6_no_ack", 64'(acks_cpu + acks_dma - n0), 64'(0));
      chk("t6_idle", 64'(ia.arb_busy), 64'(0));
      rsp_dly_fix = 0;
      raise_cpu(23'h000ABC, 1'b0, 4'h5, 32'h0);
      wait_ack(0, 20, "t6_next_ack");
      drain("t6_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
